// File: rtl/rf_wb_arbiter.sv
// Round-robin write-back arbiter for the register file write port, plus a
// pending-write scoreboard used by issue logic for read-after-write hazard checks.
module rf_wb_arbiter #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*XLEN-1:0] req_data,
    output logic                 rf_we3,
    output logic [AW-1:0]        rf_a3,
    output logic [XLEN-1:0]      rf_wd3,
    input  logic                 sb_set,
    input  logic [AW-1:0]        sb_set_addr,
    input  logic [AW-1:0]        q_a1,
    input  logic [AW-1:0]        q_a2,
    output logic                 q_busy1,
    output logic                 q_busy2,
    output logic [(1<<AW)-1:0]   sb_busy
);

    localparam int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned NREG = 1 << AW;

    logic [PW-1:0]   r_rr_ptr;
    logic            r_we3;
    logic [AW-1:0]   r_a3;
    logic [XLEN-1:0] r_wd3;
    logic [NREG-1:0] r_sb;

    logic [NREQ-1:0] w_grant;
    logic [PW-1:0]   w_gidx;
    logic [PW-1:0]   w_idx;
    logic            w_acc;
    logic [AW-1:0]   w_gaddr;
    logic [XLEN-1:0] w_gdata;
    logic [NREG-1:0] w_sb_nxt;

    // Round-robin search starting just after the last accepted requester.
    always_comb begin
        w_grant = '0;
        w_gidx  = '0;
        w_idx   = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            w_idx = PW'((32'(r_rr_ptr) + k) % NREQ);
            if (w_grant == '0 && req_valid[w_idx]) begin
                w_grant[w_idx] = 1'b1;
                w_gidx         = w_idx;
            end
        end
    end

    always_comb begin
        w_gaddr = '0;
        w_gdata = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_gaddr = req_addr[i*AW +: AW];
                w_gdata = req_data[i*XLEN +: XLEN];
            end
        end
    end

    assign w_acc     = |w_grant;
    assign req_ready = w_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= PW'(NREQ - 1);
        end else if (w_acc) begin
            r_rr_ptr <= w_gidx;
        end
    end

    // Write stage: x0 accepts are consumed without touching the register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we3 <= 1'b0;
            r_a3  <= '0;
            r_wd3 <= '0;
        end else begin
            r_we3 <= w_acc && (w_gaddr != '0);
            if (w_acc && (w_gaddr != '0)) begin
                r_a3  <= w_gaddr;
                r_wd3 <= w_gdata;
            end
        end
    end

    // Clear applied before set so a newer producer keeps the bit busy.
    always_comb begin
        w_sb_nxt = r_sb;
        if (r_we3) begin
            w_sb_nxt[r_a3] = 1'b0;
        end
        if (sb_set) begin
            w_sb_nxt[sb_set_addr] = 1'b1;
        end
        w_sb_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sb <= '0;
        end else begin
            r_sb <= w_sb_nxt;
        end
    end

    assign rf_we3  = r_we3;
    assign rf_a3   = r_a3;
    assign rf_wd3  = r_wd3;
    assign sb_busy = r_sb;
    assign q_busy1 = r_sb[q_a1];
    assign q_busy2 = r_sb[q_a2];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: grants, write stage, x0 handling,
// scoreboard set/clear collisions and asynchronous reset.
module tb_rf_wb_arbiter;

    localparam int unsigned NREQ = 3;
    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 5;

    logic                 clk;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*XLEN-1:0] req_data;
    logic                 rf_we3;
    logic [AW-1:0]        rf_a3;
    logic [XLEN-1:0]      rf_wd3;
    logic                 sb_set;
    logic [AW-1:0]        sb_set_addr;
    logic [AW-1:0]        q_a1;
    logic [AW-1:0]        q_a2;
    logic                 q_busy1;
    logic                 q_busy2;
    logic [31:0]          sb_busy;

    int n_cmp;
    int n_bad;

    rf_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .rf_we3      (rf_we3),
        .rf_a3       (rf_a3),
        .rf_wd3      (rf_wd3),
        .sb_set      (sb_set),
        .sb_set_addr (sb_set_addr),
        .q_a1        (q_a1),
        .q_a2        (q_a2),
        .q_busy1     (q_busy1),
        .q_busy2     (q_busy2),
        .sb_busy     (sb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [2:0]  exp_g [4];
    logic [4:0]  exp_a [4];
    logic [31:0] exp_d [4];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        req_valid = '0;
        req_addr = '0;
        req_data = '0;
        sb_set = 1'b0;
        sb_set_addr = '0;
        q_a1 = '0;
        q_a2 = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_we3", 32'(rf_we3), 32'd0);
        chk("rst_a3", 32'(rf_a3), 32'd0);
        chk("rst_wd3", rf_wd3, 32'd0);
        chk("rst_sb", sb_busy, 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;

        // Single request from requester 0
        req_valid = 3'b001;
        req_addr[0*AW +: AW] = 5'd1;
        req_data[0*XLEN +: XLEN] = 32'h0000FFFF;
        #1;
        chk("single_ready", 32'(req_ready), 32'b001);
        tick();
        req_valid = '0;
        #1;
        chk("single_we3", 32'(rf_we3), 32'd1);
        chk("single_a3", 32'(rf_a3), 32'd1);
        chk("single_wd3", rf_wd3, 32'h0000FFFF);
        tick();
        chk("single_we3_off", 32'(rf_we3), 32'd0);
        chk("single_a3_hold", 32'(rf_a3), 32'd1);

        // Round-robin: last accept was requester 0, so order is 1,2,0,1
        exp_g[0] = 3'b010; exp_a[0] = 5'd2; exp_d[0] = 32'hB;
        exp_g[1] = 3'b100; exp_a[1] = 5'd3; exp_d[1] = 32'hC;
        exp_g[2] = 3'b001; exp_a[2] = 5'd1; exp_d[2] = 32'hA;
        exp_g[3] = 3'b010; exp_a[3] = 5'd2; exp_d[3] = 32'hB;
        req_addr[0*AW +: AW] = 5'd1;
        req_addr[1*AW +: AW] = 5'd2;
        req_addr[2*AW +: AW] = 5'd3;
        req_data[0*XLEN +: XLEN] = 32'hA;
        req_data[1*XLEN +: XLEN] = 32'hB;
        req_data[2*XLEN +: XLEN] = 32'hC;
        req_valid = 3'b111;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rr_grant%0d", k), 32'(req_ready), 32'(exp_g[k]));
            tick();
            chk($sformatf("rr_we3_%0d", k), 32'(rf_we3), 32'd1);
            chk($sformatf("rr_a3_%0d", k), 32'(rf_a3), 32'(exp_a[k]));
            chk($sformatf("rr_wd3_%0d", k), rf_wd3, exp_d[k]);
        end
        req_valid = '0;
        tick();
        chk("rr_idle_we3", 32'(rf_we3), 32'd0);

        // x0 write: granted and accepted, never reaches the register file
        req_addr[1*AW +: AW] = 5'd0;
        req_data[1*XLEN +: XLEN] = 32'hFFFF0000;
        req_valid = 3'b010;
        #1;
        chk("x0_ready", 32'(req_ready), 32'b010);
        chk("x0_we3_pre", 32'(rf_we3), 32'd0);
        tick();
        req_valid = '0;
        #1;
        chk("x0_we3", 32'(rf_we3), 32'd0);
        chk("x0_ready_off", 32'(req_ready), 32'd0);
        chk("x0_sb", sb_busy, 32'd0);
        tick();
        chk("x0_we3_late", 32'(rf_we3), 32'd0);

        // Scoreboard set, then write-back clears
        sb_set = 1'b1;
        sb_set_addr = 5'd2;
        tick();
        sb_set = 1'b0;
        q_a1 = 5'd2;
        #1;
        chk("sb_busy1_set", 32'(q_busy1), 32'd1);
        chk("sb_vec_set", sb_busy, 32'h4);
        req_addr[0*AW +: AW] = 5'd2;
        req_data[0*XLEN +: XLEN] = 32'hFFFF0000;
        req_valid = 3'b001;
        #1;
        chk("sb_wr_ready", 32'(req_ready), 32'b001);
        tick();
        req_valid = '0;
        #1;
        chk("sb_wr_we3", 32'(rf_we3), 32'd1);
        chk("sb_wr_a3", 32'(rf_a3), 32'd2);
        chk("sb_wr_wd3", rf_wd3, 32'hFFFF0000);
        chk("sb_busy1_wait", 32'(q_busy1), 32'd1);
        tick();
        chk("sb_busy1_clr", 32'(q_busy1), 32'd0);
        chk("sb_vec_clr", sb_busy, 32'd0);
        sb_set = 1'b1;
        sb_set_addr = 5'd0;
        tick();
        sb_set = 1'b0;
        q_a2 = 5'd0;
        #1;
        chk("sb_x0_vec", sb_busy, 32'd0);
        chk("sb_x0_busy2", 32'(q_busy2), 32'd0);

        // Same-address set/clear collision: set wins
        req_addr[1*AW +: AW] = 5'd5;
        req_data[1*XLEN +: XLEN] = 32'h55;
        req_valid = 3'b010;
        tick();
        req_valid = '0;
        sb_set = 1'b1;
        sb_set_addr = 5'd5;
        #1;
        chk("col5_we3", 32'(rf_we3), 32'd1);
        chk("col5_a3", 32'(rf_a3), 32'd5);
        tick();
        sb_set = 1'b0;
        q_a2 = 5'd5;
        #1;
        chk("col5_vec", sb_busy, 32'h20);
        chk("col5_busy2", 32'(q_busy2), 32'd1);

        // Different-address set/clear: both apply
        sb_set = 1'b1;
        sb_set_addr = 5'd6;
        tick();
        sb_set = 1'b0;
        req_addr[2*AW +: AW] = 5'd6;
        req_data[2*XLEN +: XLEN] = 32'h66;
        req_valid = 3'b100;
        #1;
        chk("col6_vec_pre", sb_busy, 32'h60);
        chk("col6_ready", 32'(req_ready), 32'b100);
        tick();
        req_valid = '0;
        sb_set = 1'b1;
        sb_set_addr = 5'd7;
        #1;
        chk("col6_a3", 32'(rf_a3), 32'd6);
        tick();
        sb_set = 1'b0;
        #1;
        chk("col67_vec", sb_busy, 32'hA0);

        // Async reset right after an accept
        req_addr[2*AW +: AW] = 5'd4;
        req_data[2*XLEN +: XLEN] = 32'h44;
        req_valid = 3'b100;
        tick();
        req_valid = '0;
        chk("ar_we3_pre", 32'(rf_we3), 32'd1);
        chk("ar_a3_pre", 32'(rf_a3), 32'd4);
        rst_n = 1'b0;
        #1;
        chk("ar_we3", 32'(rf_we3), 32'd0);
        chk("ar_sb", sb_busy, 32'd0);
        chk("ar_a3", 32'(rf_a3), 32'd0);
        tick();
        rst_n = 1'b1;
        req_valid = 3'b111;
        #1;
        chk("ar_first_grant", 32'(req_ready), 32'b001);
        tick();
        req_valid = '0;
        #1;
        chk("ar_first_a3", 32'(rf_a3), 32'd2);
        chk("ar_first_wd3", rf_wd3, 32'hFFFF0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
